// File: rtl/obb_projector.sv
// OBB interval projector: one shared signed multiplier over 8 steps.
// Optional overlap test against a reference interval: OBB_PROJ_OVERLAP_EN.
module obb_projector #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] cx,
  input  logic [W-1:0] cy,
  input  logic [W-1:0] u0x,
  input  logic [W-1:0] u0y,
  input  logic [W-1:0] u1x,
  input  logic [W-1:0] u1y,
  input  logic [W-1:0] h0,
  input  logic [W-1:0] h1,
  input  logic [W-1:0] ax,
  input  logic [W-1:0] ay,
`ifdef OBB_PROJ_OVERLAP_EN
  input  logic [W-1:0] ref_min,
  input  logic [W-1:0] ref_max,
  output logic         out_overlap,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_min,
  output logic [W-1:0] out_max
);

  typedef enum logic [1:0] {IDLE, MUL, FIN, DONE} state_t;

  localparam logic signed [W-1:0] MAXW = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINW = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [2*W:0] ACC_HI = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] ACC_LO = {{(W+2){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [W+1:0] FIN_HI = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] FIN_LO = {3'b111, {(W-1){1'b0}}};

  state_t state, state_n;
  logic [2:0] step;

  logic signed [W-1:0] cx_q, cy_q, u0x_q, u0y_q, u1x_q, u1y_q;
  logic signed [W-1:0] h0_q, h1_q, ax_q, ay_q;
  logic signed [W-1:0] pc, d0, d1, r0, r1;
  logic signed [2*W:0] acc;

  logic signed [W-1:0]   ma, mb;
  logic signed [2*W-1:0] prod;
  logic signed [2*W:0]   addend, sum, sh;
  logic signed [W-1:0]   dsat;
  logic [W:0]            rsum;
  logic signed [W+1:0]   lo, hi;
  logic signed [W-1:0]   lo_s, hi_s;

`ifdef OBB_PROJ_OVERLAP_EN
  logic signed [W-1:0] ref_min_q, ref_max_q;
`endif

  function automatic logic signed [W-1:0] sabs(input logic signed [W-1:0] v);
    if (v == MINW) return MAXW;
    return v[W-1] ? -v : v;
  endfunction

  function automatic logic signed [W-1:0] sat_acc(input logic signed [2*W:0] v);
    if (v > ACC_HI) return MAXW;
    if (v < ACC_LO) return MINW;
    return v[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] sat_fin(input logic signed [W+1:0] v);
    if (v > FIN_HI) return MAXW;
    if (v < FIN_LO) return MINW;
    return v[W-1:0];
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    ma = '0;
    mb = '0;
    case (step)
      3'd0:    begin ma = cx_q;     mb = ax_q; end
      3'd1:    begin ma = cy_q;     mb = ay_q; end
      3'd2:    begin ma = u0x_q;    mb = ax_q; end
      3'd3:    begin ma = u0y_q;    mb = ay_q; end
      3'd4:    begin ma = sabs(d0); mb = h0_q; end
      3'd5:    begin ma = u1x_q;    mb = ax_q; end
      3'd6:    begin ma = u1y_q;    mb = ay_q; end
      default: begin ma = sabs(d1); mb = h1_q; end
    endcase
  end

  // Second half of each dot product adds the held first product.
  assign prod   = ma * mb;
  assign addend = (step == 3'd1 || step == 3'd3 || step == 3'd6) ? acc : '0;
  assign sum    = addend + $signed({prod[2*W-1], prod});
  assign sh     = sum >>> FRAC;
  assign dsat   = sat_acc(sh);

  assign rsum = {1'b0, r0} + {1'b0, r1};
  assign lo   = $signed({{2{pc[W-1]}}, pc}) - $signed({1'b0, rsum});
  assign hi   = $signed({{2{pc[W-1]}}, pc}) + $signed({1'b0, rsum});
  assign lo_s = sat_fin(lo);
  assign hi_s = sat_fin(hi);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = MUL;
      MUL:     if (step == 3'd7) state_n = FIN;
      FIN:     state_n = DONE;
      default: if (out_ready) state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= '0;
      cx_q <= '0; cy_q <= '0; u0x_q <= '0; u0y_q <= '0;
      u1x_q <= '0; u1y_q <= '0; h0_q <= '0; h1_q <= '0;
      ax_q <= '0; ay_q <= '0;
      pc <= '0; d0 <= '0; d1 <= '0; r0 <= '0; r1 <= '0;
      acc <= '0;
      out_min <= '0;
      out_max <= '0;
`ifdef OBB_PROJ_OVERLAP_EN
      ref_min_q <= '0;
      ref_max_q <= '0;
      out_overlap <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          step  <= '0;
          acc   <= '0;
          cx_q  <= cx;  cy_q  <= cy;
          u0x_q <= u0x; u0y_q <= u0y;
          u1x_q <= u1x; u1y_q <= u1y;
          ax_q  <= ax;  ay_q  <= ay;
          h0_q  <= h0[W-1] ? '0 : h0;
          h1_q  <= h1[W-1] ? '0 : h1;
`ifdef OBB_PROJ_OVERLAP_EN
          ref_min_q <= ref_min;
          ref_max_q <= ref_max;
`endif
        end
        MUL: begin
          step <= step + 3'd1;
          case (step)
            3'd1:    pc <= dsat;
            3'd3:    d0 <= dsat;
            3'd4:    r0 <= dsat;
            3'd6:    d1 <= dsat;
            3'd7:    r1 <= dsat;
            default: acc <= sum;
          endcase
        end
        FIN: begin
          out_min <= lo_s;
          out_max <= hi_s;
`ifdef OBB_PROJ_OVERLAP_EN
          out_overlap <= (lo_s <= ref_max_q) && (ref_min_q <= hi_s);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_obb_projector.sv
// Scoreboard bench for obb_projector: directed cases, backpressure,
// mid-job reset and a few random operand sets against a behavioural model.
module tb_obb_projector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [15:0] cx, cy, u0x, u0y, u1x, u1y, h0, h1, ax, ay;
  logic [15:0] out_min, out_max;
`ifdef OBB_PROJ_OVERLAP_EN
  logic [15:0] ref_min = '0, ref_max = '0;
  logic out_overlap;
`endif

  typedef struct packed {
    logic [15:0] mn;
    logic [15:0] mx;
    logic        ov;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  obb_projector #(.W(16), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .cx(cx), .cy(cy), .u0x(u0x), .u0y(u0y), .u1x(u1x), .u1y(u1y),
    .h0(h0), .h1(h1), .ax(ax), .ay(ay),
`ifdef OBB_PROJ_OVERLAP_EN
    .ref_min(ref_min), .ref_max(ref_max), .out_overlap(out_overlap),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_max(out_max)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic setops(input int a, b, c, d, f, g, h, i, j, k);
    cx = a[15:0]; cy = b[15:0]; u0x = c[15:0]; u0y = d[15:0];
    u1x = f[15:0]; u1y = g[15:0]; h0 = h[15:0]; h1 = i[15:0];
    ax = j[15:0]; ay = k[15:0];
  endtask

  function automatic longint sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint mag(input longint v);
    if (v == -32768) return 32767;
    return (v < 0) ? -v : v;
  endfunction

  function automatic longint sx(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic void model(output int mn, output int mx);
    longint p, a0, a1, q0, q1, hh0, hh1;
    p   = sat((sx(cx) * sx(ax) + sx(cy) * sx(ay)) >>> 8);
    a0  = sat((sx(u0x) * sx(ax) + sx(u0y) * sx(ay)) >>> 8);
    a1  = sat((sx(u1x) * sx(ax) + sx(u1y) * sx(ay)) >>> 8);
    hh0 = (sx(h0) < 0) ? 0 : sx(h0);
    hh1 = (sx(h1) < 0) ? 0 : sx(h1);
    q0  = sat((mag(a0) * hh0) >>> 8);
    q1  = sat((mag(a1) * hh1) >>> 8);
    mn  = int'(sat(p - (q0 + q1)));
    mx  = int'(sat(p + (q0 + q1)));
  endfunction

  task automatic push(input int mn, input int mx);
    exp_t x;
    x.mn = mn[15:0];
    x.mx = mx[15:0];
    x.ov = 1'b0;
`ifdef OBB_PROJ_OVERLAP_EN
    x.ov = (mn <= int'($signed(ref_max))) && (int'($signed(ref_min)) <= mx);
`endif
    q.push_back(x);
  endtask

  // Called at a negedge with in_valid already high; returns after E0's negedge.
  task automatic accept(input string tag);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic latency(input string tag);
    int lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!out_valid && lat < 40);
    chk({tag, "_latency"}, 32'(lat), 32'd9);
    @(negedge clk);
  endtask

  task automatic compare(input string tag);
    if (q.size() == 0) begin
      chk({tag, "_queue_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({tag, "_min"}, 32'(out_min), 32'(e.mn));
      chk({tag, "_max"}, 32'(out_max), 32'(e.mx));
`ifdef OBB_PROJ_OVERLAP_EN
      chk({tag, "_overlap"}, 32'(out_overlap), 32'(e.ov));
`endif
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic job(input string tag, input int mn, input int mx);
    @(negedge clk);
    in_valid = 1'b1;
    push(mn, mx);
    accept(tag);
    latency(tag);
    compare(tag);
    handshake(tag);
  endtask

  initial begin
    int mn, mx;
    setops(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_min", 32'(out_min), 32'd0);
    chk("rst_max", 32'(out_max), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    setops(2560, 0, 256, 0, 0, 256, 512, 256, 256, 0);
    job("aligned", 2048, 3072);
    setops(2560, 0, -256, 0, 0, 256, 512, 256, 256, 0);
    job("flipped", 2048, 3072);
    setops(32767, 32767, 256, 0, 0, 256, 256, 256, 256, 256);
    job("sat_hi", 32255, 32767);
    setops(-2560, 0, 256, 0, 0, 256, 512, 256, 256, 0);
    job("neg_center", -3072, -2048);
    setops(-32768, -32768, 256, 0, 0, 256, 256, 256, 256, 256);
    job("sat_lo", -32768, -32256);
    setops(0, 0, -32768, 0, 0, 256, 256, 256, 256, 0);
    job("abs_min", -32767, 32767);
    setops(2560, 0, 256, 0, 0, 256, -5, 256, 256, 0);
    job("neg_h0", 2560, 2560);

    // Backpressure: result A held while operands churn, then B accepted.
    setops(2560, 0, 256, 0, 0, 256, 512, 256, 256, 0);
    @(negedge clk);
    in_valid = 1'b1;
    push(2048, 3072);
    accept("bp_a");
    latency("bp_a");
    compare("bp_a");
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      setops(i * 100, -i * 50, 256, 0, 0, 256, 100 + i, 200, 256, 256);
      @(negedge clk);
      chk("bp_hold_min", 32'(out_min), 32'(16'd2048));
      chk("bp_hold_max", 32'(out_max), 32'(16'd3072));
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    setops(1000, 500, 256, 0, 0, 256, 256, 128, 256, 256);
    model(mn, mx);
    push(mn, mx);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_ready_next", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    latency("bp_b");
    compare("bp_b");
    handshake("bp_b");

    // Reset asserted while step 4 is in flight.
    setops(5000, 0, 256, 0, 0, 256, 512, 256, 256, 0);
    @(negedge clk);
    in_valid = 1'b1;
    accept("rst_job");
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_min", 32'(out_min), 32'd0);
    chk("mid_rst_max", 32'(out_max), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_quiet", 32'(out_valid), 32'd0);
    setops(2560, 0, 256, 0, 0, 256, 512, 256, 256, 0);
    job("post_rst", 2048, 3072);

    for (int i = 0; i < 4; i++) begin
      setops(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
             int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
             int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
             int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
             int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      model(mn, mx);
      job("random", mn, mx);
    end

`ifdef OBB_PROJ_OVERLAP_EN
    setops(2560, 0, 256, 0, 0, 256, 512, 256, 256, 0);
    ref_min = 16'd3072;
    ref_max = 16'd4000;
    job("ov_touch", 2048, 3072);
    ref_min = 16'd3073;
    job("ov_gap", 2048, 3072);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
